// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and the load/store unit. LSU has priority; a starvation counter forces a
// fetch win after STARVE_LIMIT consecutive LSU wins over a pending fetch.
// One transaction is outstanding at most (IDLE -> REQ -> WAIT -> IDLE).
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // instruction fetch port
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  // load/store unit port
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_be,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,
  // memory bus
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  // status
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Counter is 4 bits wide, enough for the full 1..15 limit range.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic        cmd_we_q, cmd_we_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [3:0]  cmd_be_q, cmd_be_d;

  logic        lsu_wins;

  // LSU wins unless fetch is pending and has been starved to the limit.
  always_comb begin
    lsu_wins = i_lsu_req && !(i_if_req && (starve_cnt_q == LIMIT));
  end

  // Next-state, command latch, grant and completion steering.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_lsu_d  = owner_lsu_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    o_if_gnt     = 1'b0;
    o_lsu_gnt    = 1'b0;
    o_if_rvalid  = 1'b0;
    o_lsu_rvalid = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_if_req || i_lsu_req) begin
          state_d = REQ;
          if (lsu_wins) begin
            o_lsu_gnt   = 1'b1;
            owner_lsu_d = 1'b1;
            cmd_we_d    = i_lsu_we;
            cmd_addr_d  = i_lsu_addr;
            cmd_wdata_d = i_lsu_wdata;
            cmd_be_d    = i_lsu_be;
            // Only a win over a pending fetch counts toward starvation.
            if (i_if_req && (starve_cnt_q != LIMIT)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end else begin
            o_if_gnt     = 1'b1;
            owner_lsu_d  = 1'b0;
            cmd_we_d     = 1'b0;
            cmd_addr_d   = i_if_addr;
            cmd_wdata_d  = 32'd0;
            cmd_be_d     = 4'hF;
            starve_cnt_d = 4'd0;
          end
        end
      end
      REQ: begin
        // Any rvalid here is a protocol violation and is ignored.
        if (i_mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          o_lsu_rvalid = owner_lsu_q;
          o_if_rvalid  = !owner_lsu_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Combinational handshakes are silenced while reset is applied so that
    // neither requester sees a grant or completion that will be abandoned.
    if (i_reset) begin
      o_if_gnt     = 1'b0;
      o_lsu_gnt    = 1'b0;
      o_if_rvalid  = 1'b0;
      o_lsu_rvalid = 1'b0;
    end
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      owner_lsu_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      cmd_be_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_lsu_q  <= owner_lsu_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
    end
  end

  // Memory bus and status are straight decodes of registered state.
  always_comb begin
    o_mem_req   = (state_q == REQ);
    o_mem_we    = cmd_we_q;
    o_mem_addr  = cmd_addr_q;
    o_mem_wdata = cmd_wdata_q;
    o_mem_be    = cmd_be_q;
    o_busy      = (state_q != IDLE);
    o_if_rdata  = i_mem_rdata;
    o_lsu_rdata = i_mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_lsu_req;
  logic        i_lsu_we;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_be;
  logic        o_lsu_gnt;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  int checks_cnt;
  int fail_cnt;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_lsu_req    (i_lsu_req),
    .i_lsu_we     (i_lsu_we),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .i_lsu_be     (i_lsu_be),
    .o_lsu_gnt    (o_lsu_gnt),
    .o_lsu_rvalid (o_lsu_rvalid),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  // Grant order for both requesters held high, limit 4 (1 = fetch).
  logic [9:0] exp_fetch_win;
  logic [3:0] exp_cnt [10];

  initial begin
    checks_cnt   = 0;
    fail_cnt     = 0;
    i_reset      = 1'b1;
    i_if_req     = 1'b0;
    i_if_addr    = 32'd0;
    i_lsu_req    = 1'b0;
    i_lsu_we     = 1'b0;
    i_lsu_addr   = 32'd0;
    i_lsu_wdata  = 32'd0;
    i_lsu_be     = 4'd0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    exp_fetch_win = 10'b10000_10000; // bit i: iteration i; bits 4 and 9 are fetch
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    // ---------------- reset state ----------------
    tick(); tick();
    i_if_req  = 1'b1;
    i_lsu_req = 1'b1;
    settle();
    check_val("rst_if_gnt",   32'(o_if_gnt), 32'd0);
    check_val("rst_lsu_gnt",  32'(o_lsu_gnt), 32'd0);
    check_val("rst_mem_req",  32'(o_mem_req), 32'd0);
    check_val("rst_mem_we",   32'(o_mem_we), 32'd0);
    check_val("rst_mem_addr", o_mem_addr, 32'd0);
    check_val("rst_mem_wdata", o_mem_wdata, 32'd0);
    check_val("rst_mem_be",   32'(o_mem_be), 32'd0);
    check_val("rst_busy",     32'(o_busy), 32'd0);
    i_if_req  = 1'b0;
    i_lsu_req = 1'b0;
    tick();
    i_reset = 1'b0;
    tick();

    // ---------------- fetch only ----------------
    i_if_req  = 1'b1;
    i_if_addr = 32'h100;
    settle();
    check_val("f_if_gnt_c0",  32'(o_if_gnt), 32'd1);
    check_val("f_lsu_gnt_c0", 32'(o_lsu_gnt), 32'd0);
    tick();
    i_if_req  = 1'b0;
    i_if_addr = 32'hFFFF_0000;
    i_mem_gnt = 1'b1;
    settle();
    check_val("f_mem_req_c1",  32'(o_mem_req), 32'd1);
    check_val("f_mem_addr_c1", o_mem_addr, 32'h100);
    check_val("f_mem_we_c1",   32'(o_mem_we), 32'd0);
    check_val("f_mem_be_c1",   32'(o_mem_be), 32'hF);
    check_val("f_busy_c1",     32'(o_busy), 32'd1);
    tick();
    i_mem_gnt = 1'b0;
    settle();
    check_val("f_mem_req_c2",   32'(o_mem_req), 32'd0);
    check_val("f_if_rvalid_c2", 32'(o_if_rvalid), 32'd0);
    tick();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hDEADBEEF;
    settle();
    check_val("f_if_rvalid_c3",  32'(o_if_rvalid), 32'd1);
    check_val("f_if_rdata_c3",   o_if_rdata, 32'hDEADBEEF);
    check_val("f_lsu_rvalid_c3", 32'(o_lsu_rvalid), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    settle();
    check_val("f_busy_done", 32'(o_busy), 32'd0);

    // ---------------- LSU store with gnt stall ----------------
    i_lsu_req   = 1'b1;
    i_lsu_we    = 1'b1;
    i_lsu_addr  = 32'h2004;
    i_lsu_wdata = 32'h55AA;
    i_lsu_be    = 4'h3;
    settle();
    check_val("s_lsu_gnt", 32'(o_lsu_gnt), 32'd1);
    check_val("s_if_gnt",  32'(o_if_gnt), 32'd0);
    tick();
    i_lsu_req   = 1'b0;
    i_lsu_we    = 1'b0;
    i_lsu_addr  = 32'hBAD0_BAD0;
    i_lsu_wdata = 32'h1234_5678;
    i_lsu_be    = 4'hC;
    for (int k = 0; k < 5; k++) begin
      i_mem_gnt = (k == 4);
      settle();
      check_val($sformatf("s_req%0d_req", k),   32'(o_mem_req), 32'd1);
      check_val($sformatf("s_req%0d_we", k),    32'(o_mem_we), 32'd1);
      check_val($sformatf("s_req%0d_addr", k),  o_mem_addr, 32'h2004);
      check_val($sformatf("s_req%0d_wdata", k), o_mem_wdata, 32'h55AA);
      check_val($sformatf("s_req%0d_be", k),    32'(o_mem_be), 32'h3);
      tick();
    end
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0;
    settle();
    check_val("s_lsu_rvalid", 32'(o_lsu_rvalid), 32'd1);
    check_val("s_if_rvalid",  32'(o_if_rvalid), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;

    // ---------------- simultaneous requests ----------------
    i_if_req    = 1'b1;
    i_if_addr   = 32'h1000;
    i_lsu_req   = 1'b1;
    i_lsu_we    = 1'b0;
    i_lsu_addr  = 32'h2000;
    i_lsu_wdata = 32'h0;
    i_lsu_be    = 4'hF;
    for (int k = 0; k < 10; k++) begin
      settle();
      check_val($sformatf("arb%0d_if_gnt", k),  32'(o_if_gnt),  32'(exp_fetch_win[k]));
      check_val($sformatf("arb%0d_lsu_gnt", k), 32'(o_lsu_gnt), 32'(!exp_fetch_win[k]));
      tick();
      if (k == 9) begin
        i_if_req  = 1'b0;
        i_lsu_req = 1'b0;
      end
      i_mem_gnt = 1'b1;
      settle();
      check_val($sformatf("arb%0d_cnt", k), 32'(dut.starve_cnt_q), 32'(exp_cnt[k]));
      check_val($sformatf("arb%0d_addr", k), o_mem_addr,
                exp_fetch_win[k] ? 32'h1000 : 32'h2000);
      tick();
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hA000_0000 + 32'(k);
      settle();
      check_val($sformatf("arb%0d_rv", k),
                {30'd0, o_if_rvalid, o_lsu_rvalid},
                exp_fetch_win[k] ? 32'd2 : 32'd1);
      tick();
      i_mem_rvalid = 1'b0;
    end

    // ---------------- protocol: rvalid in IDLE and REQ ----------------
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hCAFE_0001;
    settle();
    check_val("p_idle_rv", {30'd0, o_if_rvalid, o_lsu_rvalid}, 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    settle();
    check_val("p_idle_busy", 32'(o_busy), 32'd0);
    i_if_req  = 1'b1;
    i_if_addr = 32'h300;
    settle();
    check_val("p_if_gnt", 32'(o_if_gnt), 32'd1);
    tick();
    i_if_req     = 1'b0;
    i_mem_rvalid = 1'b1;
    settle();
    check_val("p_req_rv", {30'd0, o_if_rvalid, o_lsu_rvalid}, 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    i_mem_gnt    = 1'b1;
    settle();
    check_val("p_still_req", 32'(o_mem_req), 32'd1);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0000_0300;
    settle();
    check_val("p_if_rv_done", 32'(o_if_rvalid), 32'd1);
    tick();
    i_mem_rvalid = 1'b0;

    // ---------------- reset mid-WAIT ----------------
    i_lsu_req  = 1'b1;
    i_lsu_we   = 1'b0;
    i_lsu_addr = 32'h400;
    settle();
    check_val("r_lsu_gnt", 32'(o_lsu_gnt), 32'd1);
    tick();
    i_lsu_req = 1'b0;
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_reset   = 1'b1;
    settle();
    check_val("r_wait_busy", 32'(o_busy), 32'd1);
    check_val("r_rst_rv", {30'd0, o_if_rvalid, o_lsu_rvalid}, 32'd0);
    tick();
    i_reset      = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0BAD_0400;
    settle();
    check_val("r_late_rv",  {30'd0, o_if_rvalid, o_lsu_rvalid}, 32'd0);
    check_val("r_mem_req",  32'(o_mem_req), 32'd0);
    check_val("r_mem_addr", o_mem_addr, 32'd0);
    check_val("r_mem_be",   32'(o_mem_be), 32'd0);
    check_val("r_busy",     32'(o_busy), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    i_if_req     = 1'b1;
    i_if_addr    = 32'h500;
    settle();
    check_val("r_next_gnt", 32'(o_if_gnt), 32'd1);
    tick();
    i_if_req  = 1'b0;
    i_mem_gnt = 1'b1;
    settle();
    check_val("r_next_addr", o_mem_addr, 32'h500);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0000_0500;
    settle();
    check_val("r_next_rv",    32'(o_if_rvalid), 32'd1);
    check_val("r_next_rdata", o_if_rdata, 32'h0000_0500);
    tick();
    i_mem_rvalid = 1'b0;

    // ---------------- back-to-back: LSU load then fetch ----------------
    i_lsu_req  = 1'b1;
    i_lsu_we   = 1'b0;
    i_lsu_addr = 32'h600;
    settle();
    check_val("b_lsu_gnt", 32'(o_lsu_gnt), 32'd1);
    tick();
    i_lsu_req = 1'b0;
    i_if_req  = 1'b1;
    i_if_addr = 32'h700;
    i_mem_gnt = 1'b1;
    settle();
    check_val("b_req_no_gnt", 32'(o_if_gnt), 32'd0);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1111_1111;
    settle();
    check_val("b_wait_no_gnt", 32'(o_if_gnt), 32'd0);
    check_val("b_lsu_rv",      32'(o_lsu_rvalid), 32'd1);
    check_val("b_lsu_rdata",   o_lsu_rdata, 32'h1111_1111);
    check_val("b_if_rv_0",     32'(o_if_rvalid), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    settle();
    check_val("b_if_gnt", 32'(o_if_gnt), 32'd1);
    tick();
    i_if_req  = 1'b0;
    i_mem_gnt = 1'b1;
    settle();
    check_val("b_if_addr", o_mem_addr, 32'h700);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h2222_2222;
    settle();
    check_val("b_if_rv",    32'(o_if_rvalid), 32'd1);
    check_val("b_if_rdata", o_if_rdata, 32'h2222_2222);
    check_val("b_lsu_rv_0", 32'(o_lsu_rvalid), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
